// File: rtl/kcpsm6_uart_tx.sv
// Port-mapped 8N1 UART transmitter for the KCPSM6 output bus, with a write FIFO
// and a registered status byte for the in_port read mux.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | driving the start bit (low) for one bit period
// DATA  | shifting out 8 data bits, LSB first
// STOP  | driving the stop bit (high) for one bit period
`timescale 1ns/1ps
module kcpsm6_uart_tx #(
  parameter int          CLK_FREQ_HZ = 100000000,
  parameter int          BAUD        = 115200,
  parameter logic [7:0]  DATA_PORT   = 8'h01,
  parameter logic [7:0]  STATUS_PORT = 8'h02,
  parameter int          FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] status_data,
  output logic       tx
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             tx_nxt;
  logic             pop;

  logic [7:0]       mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, overflow, busy;
  logic             wr_hit, push, drop, ovf_clear;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign busy       = (state != IDLE) || !fifo_empty;

  // Fullness is taken from the registered pointers, so a pop in the same
  // cycle never makes room for a write that arrived while full.
  assign wr_hit    = write_strobe && (port_id == DATA_PORT);
  assign push      = wr_hit && !fifo_full;
  assign drop      = wr_hit && fifo_full;
  assign ovf_clear = read_strobe && (port_id == STATUS_PORT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= out_port;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      status_data <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
      status_data <= (port_id == STATUS_PORT) ?
                     {4'h0, overflow, busy, fifo_full, fifo_empty} : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
    end
  end

  // tx_nxt is the line level for the state being entered, so the register
  // output changes on the same edge as the state.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = (baud_cnt == DIV_LAST) ? '0 : baud_cnt + 1'b1;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    tx_nxt       = tx;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        tx_nxt       = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr[FIFO_AW-1:0]];
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (baud_cnt == DIV_LAST) begin
          state_nxt   = DATA;
          bit_cnt_nxt = 3'd0;
          tx_nxt      = shift[0];
        end
      end
      DATA: begin
        if (baud_cnt == DIV_LAST) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            tx_nxt      = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_cnt == DIV_LAST) begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_kcpsm6_uart_tx.sv
// Scoreboard bench for kcpsm6_uart_tx: expected bytes are queued when written
// and compared as the serial monitor decodes frames from tx.
`timescale 1ns/1ps
module tb_kcpsm6_uart_tx;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id, out_port;
  logic       write_strobe, read_strobe;
  logic [7:0] status_data;
  logic       tx;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] expq[$];
  int         starts[$];
  logic       abort    = 1'b0;
  logic       mon_busy = 1'b0;

  kcpsm6_uart_tx #(
    .CLK_FREQ_HZ(400), .BAUD(100), .DATA_PORT(8'h01), .STATUS_PORT(8'h02), .FIFO_AW(2)
  ) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .status_data(status_data), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Caller must be at a negedge; consecutive calls hit consecutive edges.
  task automatic wr(input logic [7:0] pid, input logic [7:0] d, output int c);
    port_id = pid; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    c = cyc;
    write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
  endtask

  task automatic rd_status(input string tag, input logic [7:0] exp);
    port_id = 8'h02;
    @(negedge clk);
    port_id = 8'h00;
    chk(tag, status_data, exp);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((expq.size() != 0 || mon_busy) && n < max) begin
      @(negedge clk); n++;
    end
    chk("drain_in_time", n < max, 1);
    repeat (4) @(negedge clk);
  endtask

  // Serial monitor: bits are sampled two cycles into each bit period.
  initial begin
    logic       stb, spb;
    logic [7:0] d, e;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        mon_busy = 1'b1;
        starts.push_back(cyc);
        repeat (2) @(negedge clk);
        stb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          d[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        spb = tx;
        if (!abort) begin
          if (expq.size() == 0) chk("frame_expected", expq.size(), 1);
          else begin
            e = expq.pop_front();
            chk("start_bit", stb, 1'b0);
            chk("data_byte", d, e);
            chk("stop_bit", spb, 1'b1);
          end
        end
        repeat (DIV - 2) @(negedge clk);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wa, wc, p, low;
    reset = 1'b1; port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; read_strobe = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_status", status_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // status reads when empty and idle
    rd_status("status_idle", 8'h01);
    port_id = 8'h03;
    @(negedge clk);
    chk("status_other_port", status_data, 8'h00);
    port_id = 8'h00;

    // single byte, start one cycle after the push edge
    starts.delete();
    expq.push_back(8'hA5);
    wr(8'h01, 8'hA5, wa);
    wait_drain(200);
    chk("single_start_latency", starts.size() == 1 ? starts[0] - wa : -1, 1);
    rd_status("single_not_busy", 8'h01);

    // overflow: 10 pops immediately, 11..14 fill, 15 dropped
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expq.push_back(8'h10 + 8'(i));
      wr(8'h01, 8'h10 + 8'(i), wc);
    end
    rd_status("ovf_status", 8'h0E);
    port_id = 8'h02; read_strobe = 1'b1;
    @(negedge clk);
    chk("ovf_status_on_clear", status_data, 8'h0E);
    read_strobe = 1'b0; port_id = 8'h00;
    rd_status("ovf_cleared", 8'h06);
    wait_drain(600);
    chk("ovf_frame_count", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++)
      chk("frame_spacing", starts[i] - starts[i-1], 41);

    // write-when-full on the pop edge is dropped
    for (int i = 0; i < 5; i++) begin
      expq.push_back(8'hA0 + 8'(i));
      wr(8'h01, 8'hA0 + 8'(i), wc);
      if (i == 0) wa = wc;
    end
    while (cyc < wa + 41) @(negedge clk);
    wr(8'h01, 8'hEE, wc);
    rd_status("pop_edge_drop", 8'h0C);
    expq.push_back(8'hA6);
    wr(8'h01, 8'hA6, wc);
    rd_status("after_refill", 8'h0E);
    port_id = 8'h02; read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0; port_id = 8'h00;
    rd_status("refill_cleared", 8'h06);
    wait_drain(600);

    // reset during data bit 3 of 8'h00, with more bytes queued
    wr(8'h01, 8'h00, wa);
    wr(8'h01, 8'h55, wc);
    wr(8'h01, 8'h66, wc);
    p = wa + 1;
    while (cyc < p + 17) @(negedge clk);
    chk("bit3_low", tx, 1'b0);
    abort = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_reset_tx", tx, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    chk("no_tx_after_reset", low, 0);
    rd_status("status_after_reset", 8'h01);
    abort = 1'b0;

    // non-matching port is ignored
    wr(8'h00, 8'hFF, wc);
    low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    chk("other_port_tx_idle", low, 0);
    rd_status("other_port_status", 8'h01);
    chk("scoreboard_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
